tpm_spi_regs: RTL and testbench

- TPM-over-SPI target front end combined with a small TIS register file, in one block.
- Deserialises 32-bit TPM SPI headers, inserts flow-control wait states and performs byte-wide register reads and writes.
- Maintains locality arbitration through TPM_ACCESS and holds the interrupt-enable register.
- Sits between the board SPI pins and the firmware-side TPM logic; the register write strobe is mirrored out for monitoring.

---
 rtl/tpm_spi_regs.sv | 173 +++++++++++++++++
 tb/tb_tpm_spi_regs.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/tpm_spi_regs.sv
// tpm_spi_regs: TPM-over-SPI target front end with a per-locality TIS register file.
// Ports: clk (SPI SCLK), reset (sync, active high), cs_n (frame select, active low, async frame clear),
// mosi/miso (serial data), reg_addr_o/reg_data_o/reg_wr_o (last byte address, written data, write strobe),
// active_locality_o (0..MAX_LOCALITY, 7 = none), int_enable_o (TPM_INT_ENABLE).
module tpm_spi_regs #(
    parameter int WAIT_BYTES   = 1,
    parameter int MAX_LOCALITY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic [15:0] reg_addr_o,
    output logic [7:0]  reg_data_o,
    output logic        reg_wr_o,
    output logic [2:0]  active_locality_o,
    output logic [31:0] int_enable_o
);
    typedef enum logic [1:0] {HEADER, WAIT, DATA, DONE} state_e;
    localparam logic [3:0] MAX_L     = 4'(MAX_LOCALITY);
    localparam logic [7:0] LAST_WAIT = 8'(WAIT_BYTES - 1);
    localparam bit         HAS_WAIT  = WAIT_BYTES > 0;
    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [6:0]  idx_q, idx_d;
    logic [30:0] sr_q, sr_d;
    // hdr_q = {read, size-1, address[15:0]}; the other header bits are never used
    logic [22:0] hdr_q, hdr_d;
    logic [7:0]  rd_q, rd_d;
    logic [2:0]  act_q, act_d;
    logic [31:0] ien_q, ien_d;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic        wr_q;
    logic [15:0] cur_addr;
    logic [3:0]  cur_loc;
    logic [11:0] cur_off;
    logic [7:0]  wr_data, wr_mask;
    logic        xfer, wr_en, valid, own;

    // offset wraps inside the 12-bit locality window
    function automatic logic [15:0] byte_addr(input logic [15:0] base, input logic [6:0] idx);
        return {base[15:12], base[11:0] + {5'd0, idx}};
    endfunction

    function automatic logic [7:0] rd_byte(input logic [15:0] a, input logic [2:0] act, input logic [31:0] ien);
        return (a[15:12] > MAX_L)    ? 8'hFF :
               (a[11:0] == 12'h000)  ? {2'b10, ({1'b0, act} == a[15:12]), 5'd0} :
               (a[11:2] == 10'h002)  ? ien[{a[1:0], 3'b000} +: 8] :
               (a[11:2] == 10'h004)  ? 8'h00 : 8'hFF;
    endfunction

    assign cur_addr = byte_addr(hdr_q[15:0], idx_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        hdr_d   = hdr_q;
        rd_d    = rd_q;
        xfer    = 1'b0;
        case (state_q)
            HEADER: begin
                sr_d  = {sr_q[29:0], mosi};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hdr_d   = {sr_q[30], sr_q[28:23], sr_q[14:0], mosi};
                    state_d = HAS_WAIT ? WAIT : DATA;
                    rd_d    = rd_byte(hdr_d[15:0], act_q, ien_q);
                end
            end
            WAIT: begin
                cnt_d = {2'b00, cnt_q[2:0] + 3'd1};
                if (cnt_q[2:0] == 3'd7) begin
                    wcnt_d = wcnt_q + 8'd1;
                    if (wcnt_q == LAST_WAIT) begin
                        state_d = DATA;
                        wcnt_d  = 8'd0;
                        rd_d    = rd_byte(hdr_q[15:0], act_q, ien_q);
                    end
                end
            end
            DATA: begin
                sr_d  = {sr_q[29:0], mosi};
                rd_d  = {rd_q[6:0], 1'b0};
                cnt_d = {2'b00, cnt_q[2:0] + 3'd1};
                if (cnt_q[2:0] == 3'd7) begin
                    xfer  = 1'b1;
                    idx_d = idx_q + 7'd1;
                    rd_d  = rd_byte(byte_addr(hdr_q[15:0], idx_d), act_q, ien_q);
                    state_d = (idx_q == {1'b0, hdr_q[21:16]}) ? DONE : DATA;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cur_loc = cur_addr[15:12];
        cur_off = cur_addr[11:0];
        wr_data = {sr_q[6:0], mosi};
        valid   = cur_loc <= MAX_L;
        own     = valid && ({1'b0, act_q} == cur_loc);
        wr_en   = xfer && !hdr_q[22];
        wr_mask = (cur_off[1:0] == 2'd0) ? 8'h9F : (cur_off[1:0] == 2'd3) ? 8'h80 : 8'h00;
        act_d   = act_q;
        ien_d   = ien_q;
        // relinquish is evaluated before request so 0x22 from the owner keeps ownership
        if (wr_en && valid && cur_off == 12'h000) begin
            if (wr_data[5] && own) act_d = 3'd7;
            if (wr_data[1] && act_d == 3'd7) act_d = cur_loc[2:0];
        end
        if (wr_en && own && cur_off[11:2] == 10'h002) ien_d[{cur_off[1:0], 3'b000} +: 8] = wr_data & wr_mask;
    end

    // cs_n high clears only the frame state, asynchronously, since the clock is stopped between frames
    always_ff @(posedge clk or posedge cs_n) begin
        if (cs_n) begin
            state_q <= HEADER;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            hdr_q   <= '0;
            rd_q    <= '0;
        end else if (reset) begin
            state_q <= HEADER;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            hdr_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            hdr_q   <= hdr_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q  <= 3'd7;
            ien_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            act_q <= act_d;
            ien_q <= ien_d;
            wr_q  <= wr_en && valid;
            if (xfer) addr_q <= cur_addr;
            if (wr_en) data_q <= wr_data;
        end
    end

    assign miso = (state_q == HEADER) ? (cnt_q != 5'd31 || !HAS_WAIT) :
                  (state_q == WAIT)   ? (cnt_q[2:0] == 3'd7 && wcnt_q == LAST_WAIT) :
                  (state_q == DATA)   ? (!hdr_q[22] || rd_q[7]) : 1'b1;
    assign reg_addr_o        = addr_q;
    assign reg_data_o        = data_q;
    assign reg_wr_o          = wr_q;
    assign active_locality_o = act_q;
    assign int_enable_o      = ien_q;
endmodule

// File: tb/tb_tpm_spi_regs.sv
// tb_tpm_spi_regs: directed bench for tpm_spi_regs with a miso byte scoreboard.
module tb_tpm_spi_regs;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] reg_addr_o;
    logic [7:0]  reg_data_o;
    logic        reg_wr_o;
    logic [2:0]  active_locality_o;
    logic [31:0] int_enable_o;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  cap = 8'h00;
    logic [7:0]  exp_q[$];
    string       tag_q[$];

    tpm_spi_regs dut (
        .clk(clk),
        .reset(reset),
        .cs_n(cs_n),
        .mosi(mosi),
        .miso(miso),
        .reg_addr_o(reg_addr_o),
        .reg_data_o(reg_data_o),
        .reg_wr_o(reg_wr_o),
        .active_locality_o(active_locality_o),
        .int_enable_o(int_enable_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // shifts one byte out on mosi while collecting miso; expected miso byte goes through the scoreboard
    task automatic send_byte(input logic [7:0] d, input logic [7:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            mosi = d[i];
            #1 cap = {cap[6:0], miso};
            @(posedge clk);
            #1;
        end
        chk(tag_q.pop_front(), 32'(cap), 32'(exp_q.pop_front()));
    endtask

    task automatic header(input logic [31:0] h);
        cs_n = 1'b0;
        send_byte(h[31:24], 8'hFF, "hdr_b0");
        send_byte(h[23:16], 8'hFF, "hdr_b1");
        send_byte(h[15:8], 8'hFF, "hdr_b2");
        send_byte(h[7:0], 8'hFE, "hdr_b3");
        send_byte(8'h00, 8'h01, "wait_byte");
    endtask

    task automatic end_frame();
        @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [31:0] h, input logic [7:0] d);
        header(h);
        send_byte(d, 8'hFF, "wdata");
    endtask

    task automatic rd1(input logic [31:0] h, input logic [7:0] e, input string tag);
        header(h);
        send_byte(8'h00, e, tag);
        end_frame();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_active", 32'(active_locality_o), 32'd7);
        chk("rst_ien", int_enable_o, 32'd0);
        chk("rst_wr", 32'(reg_wr_o), 32'd0);
        chk("rst_addr", 32'(reg_addr_o), 32'd0);
        chk("rst_data", 32'(reg_data_o), 32'd0);
        wr1(32'h0000_0000, 8'h02);
        chk("claim_wr", 32'(reg_wr_o), 32'd1);
        chk("claim_addr", 32'(reg_addr_o), 32'h0000);
        chk("claim_data", 32'(reg_data_o), 32'h02);
        chk("claim_active", 32'(active_locality_o), 32'd0);
        end_frame();
        chk("claim_wr_end", 32'(reg_wr_o), 32'd0);
        wr1(32'h0000_0008, 8'h83);
        chk("ien_83", int_enable_o, 32'h0000_0083);
        chk("ien_addr", 32'(reg_addr_o), 32'h0008);
        end_frame();
        wr1(32'h0000_1000, 8'h02);
        chk("l1_req_active", 32'(active_locality_o), 32'd0);
        chk("l1_req_wr", 32'(reg_wr_o), 32'd1);
        chk("l1_req_addr", 32'(reg_addr_o), 32'h1000);
        end_frame();
        rd1(32'h8000_0000, 8'hA0, "rd_access_l0");
        rd1(32'h8000_1000, 8'h80, "rd_access_l1");
        rd1(32'h8000_0F00, 8'hFF, "rd_unmapped");
        rd1(32'h8000_0008, 8'h83, "rd_ien_b0");
        rd1(32'h8000_0010, 8'h00, "rd_int_status");
        wr1(32'h0100_0008, 8'h87);
        chk("mb_ien0", int_enable_o, 32'h0000_0087);
        chk("mb_addr0", 32'(reg_addr_o), 32'h0008);
        chk("mb_data0", 32'(reg_data_o), 32'h87);
        chk("mb_wr0", 32'(reg_wr_o), 32'd1);
        send_byte(8'hFF, 8'hFF, "wdata1");
        chk("mb_ien1", int_enable_o, 32'h0000_0087);
        chk("mb_addr1", 32'(reg_addr_o), 32'h0009);
        chk("mb_data1", 32'(reg_data_o), 32'hFF);
        end_frame();
        header(32'h8100_000B);
        send_byte(8'h00, 8'h00, "rd_ien_b3");
        send_byte(8'h00, 8'hFF, "rd_off_c");
        end_frame();
        wr1(32'h0000_0000, 8'h20);
        chk("relinquish", 32'(active_locality_o), 32'd7);
        end_frame();
        wr1(32'h0000_2000, 8'h22);
        chk("l2_claim", 32'(active_locality_o), 32'd2);
        end_frame();
        wr1(32'h0000_2000, 8'h22);
        chk("l2_both", 32'(active_locality_o), 32'd2);
        end_frame();
        rd1(32'h8000_2000, 8'hA0, "rd_access_l2");
        wr1(32'h0000_2000, 8'h20);
        chk("l2_release", 32'(active_locality_o), 32'd7);
        end_frame();
        wr1(32'h0000_5000, 8'h02);
        chk("l5_wr", 32'(reg_wr_o), 32'd0);
        chk("l5_active", 32'(active_locality_o), 32'd7);
        end_frame();
        rd1(32'h8000_5000, 8'hFF, "rd_l5");
        cs_n = 1'b0;
        send_byte(8'h80, 8'hFF, "abort_b0");
        send_byte(8'h00, 8'hFF, "abort_b1");
        end_frame();
        rd1(32'h8000_0008, 8'h87, "rd_after_abort");
        wr1(32'h0000_0000, 8'h02);
        chk("reclaim", 32'(active_locality_o), 32'd0);
        end_frame();
        cs_n = 1'b0;
        send_byte(8'h00, 8'hFF, "pre_rst_b0");
        send_byte(8'h00, 8'hFF, "pre_rst_b1");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("midrst_active", 32'(active_locality_o), 32'd7);
        chk("midrst_ien", int_enable_o, 32'd0);
        rd1(32'h8000_0000, 8'h80, "rd_after_rst");
        header(32'h8100_0FFF);
        send_byte(8'h00, 8'hFF, "rd_wrap_fff");
        send_byte(8'h00, 8'h80, "rd_wrap_000");
        end_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
